// File: rtl/aes_job_sequencer.sv
// Bus master that expands one 128-bit AES job into the register wrapper's access sequence
// (config, key, init, block, next, poll, readout) and returns the result on valid/ready.
module aes_job_sequencer #(
  parameter logic [7:0] IDLE_ADDR      = 8'hE0,
  parameter int         POLL_GUARD     = 3,
  parameter int         TIMEOUT_CYCLES = 4096
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         job_valid,
  output logic         job_ready,
  input  logic [255:0] job_key,
  input  logic         job_keylen,
  input  logic         job_encdec,
  input  logic         job_key_new,
  input  logic [127:0] job_block,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [127:0] res_data,
  output logic         res_err,
  output logic         busy,
  output logic [7:0]   aes_address,
  output logic [15:0]  aes_write_data,
  input  logic [15:0]  aes_read_data
);

  localparam int                CNT_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0]  GUARD_C = CNT_W'(POLL_GUARD);
  localparam logic [CNT_W-1:0]  TOUT_C  = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_CONFIG, S_LOAD_KEY, S_INIT, S_WAIT_INIT,
    S_LOAD_BLK, S_NEXT, S_WAIT_NEXT, S_READ_RES, S_RESP
  } state_t;

  state_t             state_q;
  logic [255:0]       key_q;
  logic [127:0]       blk_q;
  logic               keylen_q;
  logic               key_new_q;
  logic               key_loaded_q;
  logic               last_keylen_q;
  logic [3:0]         idx_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               job_ready_q;
  logic               res_valid_q;
  logic [127:0]       res_data_q;
  logic               res_err_q;
  logic               busy_q;
  logic [7:0]         addr_q;
  logic [15:0]        wdata_q;

  logic               need_key_d;
  logic [3:0]         key_last_d;
  logic [3:0]         idx_inc_d;
  logic               guard_ok_d;
  logic               poll_to_d;

  // A stale or mismatched expanded key in the core must never be reused.
  assign need_key_d = key_new_q | ~key_loaded_q | (keylen_q != last_keylen_q);
  assign key_last_d = keylen_q ? 4'd15 : 4'd7;
  assign idx_inc_d  = idx_q + 4'd1;
  assign guard_ok_d = cnt_q >= GUARD_C;
  assign poll_to_d  = cnt_q == TOUT_C;

  assign job_ready      = job_ready_q;
  assign res_valid      = res_valid_q;
  assign res_data       = res_data_q;
  assign res_err        = res_err_q;
  assign busy           = busy_q;
  assign aes_address    = addr_q;
  assign aes_write_data = wdata_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      key_q         <= '0;
      blk_q         <= '0;
      keylen_q      <= 1'b0;
      key_new_q     <= 1'b0;
      key_loaded_q  <= 1'b0;
      last_keylen_q <= 1'b0;
      idx_q         <= '0;
      cnt_q         <= '0;
      job_ready_q   <= 1'b1;
      res_valid_q   <= 1'b0;
      res_data_q    <= '0;
      res_err_q     <= 1'b0;
      busy_q        <= 1'b0;
      addr_q        <= IDLE_ADDR;
      wdata_q       <= '0;
    end else begin
      // The wrapper has no strobe, so the bus parks on the unmapped address unless overridden.
      addr_q  <= IDLE_ADDR;
      wdata_q <= '0;
      unique case (state_q)
        S_IDLE: begin
          if (job_valid) begin
            key_q       <= job_key;
            blk_q       <= job_block;
            keylen_q    <= job_keylen;
            key_new_q   <= job_key_new;
            res_err_q   <= 1'b0;
            job_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            addr_q      <= {6'b010000, job_keylen, job_encdec};
            state_q     <= S_CONFIG;
          end
        end
        S_CONFIG: begin
          idx_q <= '0;
          if (need_key_d) begin
            addr_q  <= 8'h00;
            wdata_q <= key_q[255:240];
            key_q   <= key_q << 16;
            state_q <= S_LOAD_KEY;
          end else begin
            addr_q  <= 8'h10;
            wdata_q <= blk_q[127:112];
            blk_q   <= blk_q << 16;
            state_q <= S_LOAD_BLK;
          end
        end
        S_LOAD_KEY: begin
          if (idx_q == key_last_d) begin
            addr_q  <= 8'h81;
            state_q <= S_INIT;
          end else begin
            idx_q   <= idx_inc_d;
            addr_q  <= {4'h0, idx_inc_d};
            wdata_q <= key_q[255:240];
            key_q   <= key_q << 16;
          end
        end
        S_INIT: begin
          addr_q  <= 8'h60;
          cnt_q   <= '0;
          state_q <= S_WAIT_INIT;
        end
        S_WAIT_INIT: begin
          cnt_q <= cnt_q + 1'b1;
          if (guard_ok_d && aes_read_data[0]) begin
            key_loaded_q  <= 1'b1;
            last_keylen_q <= keylen_q;
            idx_q         <= '0;
            addr_q        <= 8'h10;
            wdata_q       <= blk_q[127:112];
            blk_q         <= blk_q << 16;
            state_q       <= S_LOAD_BLK;
          end else if (poll_to_d) begin
            key_loaded_q <= 1'b0;
            res_err_q    <= 1'b1;
            res_data_q   <= '0;
            res_valid_q  <= 1'b1;
            state_q      <= S_RESP;
          end else begin
            addr_q <= 8'h60;
          end
        end
        S_LOAD_BLK: begin
          if (idx_q == 4'd7) begin
            addr_q  <= 8'h82;
            state_q <= S_NEXT;
          end else begin
            idx_q   <= idx_inc_d;
            addr_q  <= {4'h1, idx_inc_d};
            wdata_q <= blk_q[127:112];
            blk_q   <= blk_q << 16;
          end
        end
        S_NEXT: begin
          addr_q  <= 8'h60;
          cnt_q   <= '0;
          state_q <= S_WAIT_NEXT;
        end
        S_WAIT_NEXT: begin
          cnt_q <= cnt_q + 1'b1;
          if (guard_ok_d && (aes_read_data[1:0] == 2'b11)) begin
            idx_q   <= '0;
            addr_q  <= 8'h20;
            state_q <= S_READ_RES;
          end else if (poll_to_d) begin
            key_loaded_q <= 1'b0;
            res_err_q    <= 1'b1;
            res_data_q   <= '0;
            res_valid_q  <= 1'b1;
            state_q      <= S_RESP;
          end else begin
            addr_q <= 8'h60;
          end
        end
        S_READ_RES: begin
          // Words arrive MSB first, so shifting left leaves word 0 in the top slot.
          res_data_q <= {res_data_q[111:0], aes_read_data};
          if (idx_q == 4'd7) begin
            res_valid_q <= 1'b1;
            state_q     <= S_RESP;
          end else begin
            idx_q  <= idx_inc_d;
            addr_q <= {4'h2, idx_inc_d};
          end
        end
        S_RESP: begin
          if (res_ready) begin
            res_valid_q <= 1'b0;
            job_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_job_sequencer.sv
// Bench for aes_job_sequencer: behavioural wrapper model with a known-answer lookup, bus monitor,
// table of jobs plus hand-written backpressure and mid-job reset sequences.
module tb_aes_job_sequencer;

  localparam logic [7:0]   IDLE = 8'hE0;
  localparam logic [127:0] PT   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C256 = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [255:0] K128 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [255:0] K256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         job_valid = 1'b0;
  logic         job_ready;
  logic [255:0] job_key = '0;
  logic         job_keylen = 1'b0;
  logic         job_encdec = 1'b0;
  logic         job_key_new = 1'b0;
  logic [127:0] job_block = '0;
  logic         res_valid;
  logic         res_ready = 1'b0;
  logic [127:0] res_data;
  logic         res_err;
  logic         busy;
  logic [7:0]   aes_address;
  logic [15:0]  aes_write_data;
  logic [15:0]  aes_read_data;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  aes_job_sequencer #(.IDLE_ADDR(IDLE), .POLL_GUARD(3), .TIMEOUT_CYCLES(64)) dut (
    .clk(clk), .reset_n(reset_n),
    .job_valid(job_valid), .job_ready(job_ready), .job_key(job_key), .job_keylen(job_keylen),
    .job_encdec(job_encdec), .job_key_new(job_key_new), .job_block(job_block),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_err(res_err),
    .busy(busy), .aes_address(aes_address), .aes_write_data(aes_write_data),
    .aes_read_data(aes_read_data)
  );

  // ---------------- wrapper model ----------------
  logic [255:0] m_key = '0, m_xkey = '0;
  logic [127:0] m_blk = '0, m_res = '0;
  logic         m_klen = 1'b0, m_enc = 1'b0, m_xklen = 1'b0;
  logic         m_ready = 1'b1, m_valid = 1'b0;
  int           m_op = 0, m_cnt = 0;
  logic         never_rdy = 1'b0;

  function automatic logic [127:0] aes_lookup(input logic klen, input logic enc,
                                              input logic [255:0] k, input logic [127:0] b);
    if (!klen && enc && k[255:128] == K128[255:128] && b == PT) return C128;
    if (klen && enc && k == K256 && b == PT) return C256;
    if (klen && !enc && k == K256 && b == C256) return PT;
    return ~b;
  endfunction

  // Status stays stale for three cycles after a pulse, then busy, then done at six.
  always @(posedge clk) begin
    if (aes_address < 8'h10)
      m_key[255 - 16*int'(aes_address[3:0]) -: 16] <= aes_write_data;
    else if (aes_address[7:3] == 5'b00010)
      m_blk[127 - 16*int'(aes_address[2:0]) -: 16] <= aes_write_data;
    else if (aes_address[7:2] == 6'b010000) begin
      m_klen <= aes_address[1];
      m_enc  <= aes_address[0];
    end
    if (aes_address == 8'h81) begin
      m_op <= 1; m_cnt <= 0; m_xkey <= m_key; m_xklen <= m_klen;
    end else if (aes_address == 8'h82) begin
      m_op <= 2; m_cnt <= 0;
    end else if (m_op != 0) begin
      m_cnt <= m_cnt + 1;
      if (m_cnt + 1 == 3) begin
        m_ready <= 1'b0;
        if (m_op == 2) m_valid <= 1'b0;
      end
      if (m_cnt + 1 == 6 && !never_rdy) begin
        m_ready <= 1'b1;
        if (m_op == 2) begin
          m_valid <= 1'b1;
          m_res   <= aes_lookup(m_xklen, m_enc, m_xkey, m_blk);
        end
        m_op <= 0;
      end
    end
  end

  always_comb begin
    aes_read_data = 16'h0;
    if (aes_address == 8'h60) aes_read_data = {14'b0, m_valid, m_ready};
    else if (aes_address[7:3] == 5'b00100)
      aes_read_data = m_res[127 - 16*int'(aes_address[2:0]) -: 16];
  end

  // ---------------- bus monitor ----------------
  int         n_init = 0, n_next = 0, n_blk = 0, n_bad = 0;
  int         key_cnt[16] = '{default: 0};
  logic [7:0] prev_addr = IDLE;

  function automatic logic legal(input logic [7:0] a);
    return a == IDLE || a < 8'h18 || (a >= 8'h20 && a < 8'h28) ||
           (a >= 8'h40 && a < 8'h44) || a == 8'h60 || a == 8'h81 || a == 8'h82;
  endfunction

  always @(posedge clk) begin
    if (aes_address < 8'h10) key_cnt[aes_address[3:0]] <= key_cnt[aes_address[3:0]] + 1;
    if (aes_address[7:3] == 5'b00010) n_blk <= n_blk + 1;
    if (aes_address == 8'h81) n_init <= n_init + 1;
    if (aes_address == 8'h82) n_next <= n_next + 1;
    if (!legal(aes_address) || (!busy && aes_address != IDLE) || (res_valid && aes_address != IDLE) ||
        ((aes_address == 8'h81 || aes_address == 8'h82) && aes_address == prev_addr))
      n_bad <= n_bad + 1;
    prev_addr <= aes_address;
  end

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    string        name;
    logic         keylen, encdec, key_new, never;
    logic [255:0] key;
    logic [127:0] blk, exp_data;
    logic         exp_err;
    logic [15:0]  exp_mask;
    int           exp_init, exp_next, exp_blk;
  } vec_t;

  function automatic vec_t mk(input string n, input logic kl, input logic enc, input logic kn,
                              input logic nev, input logic [255:0] k, input logic [127:0] b,
                              input logic [127:0] ed, input logic ee, input logic [15:0] mask,
                              input int ni, input int nn, input int nb);
    vec_t v;
    v.name = n; v.keylen = kl; v.encdec = enc; v.key_new = kn; v.never = nev;
    v.key = k; v.blk = b; v.exp_data = ed; v.exp_err = ee; v.exp_mask = mask;
    v.exp_init = ni; v.exp_next = nn; v.exp_blk = nb;
    return v;
  endfunction

  task automatic run_job(input vec_t v, input int hold);
    int ks[16];
    int i0, n0, b0, bad0, ktot;
    logic [15:0] mask;
    never_rdy = v.never;
    @(negedge clk);
    chk({v.name, ".job_ready_idle"}, 256'(job_ready), 256'(1'b1));
    for (int i = 0; i < 16; i++) ks[i] = key_cnt[i];
    i0 = n_init; n0 = n_next; b0 = n_blk; bad0 = n_bad;
    job_key = v.key; job_block = v.blk; job_keylen = v.keylen;
    job_encdec = v.encdec; job_key_new = v.key_new; job_valid = 1'b1;
    @(negedge clk);
    job_valid = 1'b0;
    job_key = ~v.key; job_block = ~v.blk; job_keylen = ~v.keylen;
    job_encdec = ~v.encdec; job_key_new = ~v.key_new;
    chk({v.name, ".accepted"}, 256'({job_ready, busy, res_err}), 256'(3'b010));
    for (int c = 0; c < 400 && res_valid !== 1'b1; c++) @(negedge clk);
    chk({v.name, ".res_valid"}, 256'(res_valid), 256'(1'b1));
    chk({v.name, ".res_data"}, 256'(res_data), 256'(v.exp_data));
    chk({v.name, ".res_err"}, 256'(res_err), 256'(v.exp_err));
    for (int c = 0; c < hold; c++) begin
      job_valid = 1'b1;
      @(negedge clk);
      chk({v.name, ".hold"}, {res_valid, job_ready, res_data}, {1'b1, 1'b0, v.exp_data});
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0; job_valid = 1'b0;
    chk({v.name, ".handshake"}, 256'({res_valid, job_ready, busy}), 256'(3'b010));
    mask = '0; ktot = 0;
    for (int i = 0; i < 16; i++) begin
      if (key_cnt[i] != ks[i]) mask[i] = 1'b1;
      ktot += key_cnt[i] - ks[i];
    end
    chk({v.name, ".key_mask"}, 256'(mask), 256'(v.exp_mask));
    chk({v.name, ".key_writes"}, 256'(ktot), 256'($countones(v.exp_mask)));
    chk({v.name, ".init_pulses"}, 256'(n_init - i0), 256'(v.exp_init));
    chk({v.name, ".next_pulses"}, 256'(n_next - n0), 256'(v.exp_next));
    chk({v.name, ".blk_writes"}, 256'(n_blk - b0), 256'(v.exp_blk));
    chk({v.name, ".bus_rules"}, 256'(n_bad - bad0), 256'(0));
    never_rdy = 1'b0;
  endtask

  task automatic chk_reset_vals(input string name);
    chk({name, ".job_ready"}, 256'(job_ready), 256'(1'b1));
    chk({name, ".res_valid"}, 256'(res_valid), 256'(1'b0));
    chk({name, ".res_data"}, 256'(res_data), 256'(0));
    chk({name, ".res_err"}, 256'(res_err), 256'(1'b0));
    chk({name, ".busy"}, 256'(busy), 256'(1'b0));
    chk({name, ".aes_address"}, 256'(aes_address), 256'(IDLE));
    chk({name, ".aes_write_data"}, 256'(aes_write_data), 256'(0));
  endtask

  vec_t vecs[9];

  initial begin
    //            name     kl  enc kn  nev key   block exp   err mask      ini nxt blk
    vecs[0] = mk("a128",   0,  1,  1,  0,  K128, PT,   C128, 0, 16'h00FF, 1,  1,  8);
    vecs[1] = mk("a256",   1,  1,  1,  0,  K256, PT,   C256, 0, 16'hFFFF, 1,  1,  8);
    vecs[2] = mk("d256",   1,  0,  0,  0,  K256, C256, PT,   0, 16'h0000, 0,  1,  8);
    vecs[3] = mk("klchg",  0,  1,  0,  0,  K128, PT,   C128, 0, 16'h00FF, 1,  1,  8);
    vecs[4] = mk("reuse",  0,  1,  0,  0,  K128, PT,   C128, 0, 16'h0000, 0,  1,  8);
    vecs[5] = mk("to_nxt", 0,  1,  0,  1,  K128, PT,   '0,   1, 16'h0000, 0,  1,  8);
    vecs[6] = mk("post_t", 0,  1,  0,  0,  K128, PT,   C128, 0, 16'h00FF, 1,  1,  8);
    vecs[7] = mk("to_ini", 1,  1,  1,  1,  K256, PT,   '0,   1, 16'hFFFF, 1,  0,  0);
    vecs[8] = mk("post_i", 1,  1,  0,  0,  K256, PT,   C256, 0, 16'hFFFF, 1,  1,  8);

    #12;
    chk_reset_vals("reset");
    @(negedge clk);
    reset_n = 1'b1;

    foreach (vecs[i]) run_job(vecs[i], 0);

    run_job(mk("bp", 0, 1, 0, 0, K128, PT, C128, 0, 16'h00FF, 1, 1, 8), 20);

    // Abandon a job in the middle of the block load; the next job must reload the key.
    @(negedge clk);
    job_key = K128; job_block = PT; job_keylen = 1'b0; job_encdec = 1'b1;
    job_key_new = 1'b0; job_valid = 1'b1;
    @(negedge clk);
    job_valid = 1'b0;
    for (int c = 0; c < 60 && aes_address !== 8'h13; c++) @(negedge clk);
    chk("midrst.reached_blk3", 256'(aes_address), 256'(8'h13));
    #2 reset_n = 1'b0;
    #1 chk_reset_vals("midrst");
    @(negedge clk);
    reset_n = 1'b1;
    run_job(mk("after_rst", 0, 1, 0, 0, K128, PT, C128, 0, 16'h00FF, 1, 1, 8), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
